// File: rtl/x_uart_pkg.sv
// Shared UART constants used by the TX, RX and FIFO blocks.
package x_uart_pkg;

   localparam int BYTE_W = 8;

endpackage

// File: rtl/x_uart_fifo_mem.sv
// Byte storage for the UART FIFOs: one synchronous write port, one
// asynchronous read port, contents are never reset.
module x_uart_fifo_mem
   import x_uart_pkg::*;
#(
   parameter int p_depth = 16
) (
   input  logic                       i_clk,
   input  logic                       i_we,
   input  logic [$clog2(p_depth)-1:0] i_waddr,
   input  logic [BYTE_W-1:0]          i_wdata,
   input  logic [$clog2(p_depth)-1:0] i_raddr,
   output logic [BYTE_W-1:0]          o_rdata
);

   logic [BYTE_W-1:0] mem_q [p_depth];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   // The read is combinational so the head byte falls through with no extra cycle.
   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/x_uart_rx_fifo.sv
// Receive FIFO behind the UART receiver: first-word-fall-through byte queue
// with occupancy, full and sticky overflow reporting.
module x_uart_rx_fifo
   import x_uart_pkg::*;
#(
   parameter int p_depth = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic [BYTE_W-1:0]        i_data,
   output logic                     o_valid,
   output logic [BYTE_W-1:0]        o_data,
   input  logic                     i_ready,
   output logic [$clog2(p_depth):0] o_level,
   output logic                     o_full,
   output logic                     o_overflow,
   input  logic                     i_clr_overflow
);

   localparam int c_aw = $clog2(p_depth);

   logic [c_aw:0]       wr_ptr_q, wr_ptr_d;
   logic [c_aw:0]       rd_ptr_q, rd_ptr_d;
   logic                ovf_q, ovf_d;
   logic                empty, full;
   logic                pop, push, ovf_evt;
   logic [BYTE_W-1:0]   mem_rdata;

   // One extra pointer bit distinguishes full from empty when the addresses match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[c_aw] != rd_ptr_q[c_aw]) &&
                  (wr_ptr_q[c_aw-1:0] == rd_ptr_q[c_aw-1:0]);

   always_comb begin
      pop      = 1'b0;
      push     = 1'b0;
      ovf_evt  = 1'b0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ovf_d    = ovf_q;

      pop     = ~empty & i_ready;
      push    = i_valid & (~full | pop);
      ovf_evt = i_valid & full & ~pop;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      // A drop in the same cycle as a clear must leave the flag set.
      if (ovf_evt) begin
         ovf_d = 1'b1;
      end else if (i_clr_overflow) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   x_uart_fifo_mem #(
      .p_depth (p_depth)
   ) u_mem (
      .i_clk   (i_clk),
      .i_we    (push),
      .i_waddr (wr_ptr_q[c_aw-1:0]),
      .i_wdata (i_data),
      .i_raddr (rd_ptr_q[c_aw-1:0]),
      .o_rdata (mem_rdata)
   );

   assign o_valid    = ~empty;
   assign o_data     = empty ? '0 : mem_rdata;
   assign o_level    = wr_ptr_q - rd_ptr_q;
   assign o_full     = full;
   assign o_overflow = ovf_q;

endmodule

// File: tb/tb_x_uart_rx_fifo.sv
// Self-checking bench for x_uart_rx_fifo: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_x_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       v   = 1'b0;
   logic [7:0] d   = 8'h00;
   logic       r   = 1'b0;
   logic       clr = 1'b0;

   logic       o_valid;
   logic [7:0] o_data;
   logic [4:0] o_level;
   logic       o_full;
   logic       o_overflow;

   always #5 clk = ~clk;

   x_uart_rx_fifo #(
      .p_depth (DEPTH)
   ) dut (
      .i_clk          (clk),
      .i_rst          (rst),
      .i_valid        (v),
      .i_data         (d),
      .o_valid        (o_valid),
      .o_data         (o_data),
      .i_ready        (r),
      .o_level        (o_level),
      .o_full         (o_full),
      .o_overflow     (o_overflow),
      .i_clr_overflow (clr)
   );

   // Reference model: the FIFO contents as a plain queue plus the sticky flag.
   logic [7:0] q[$];
   bit         m_ovf;
   int         n_cmp  = 0;
   int         n_fail = 0;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       r;
      logic       c;
      logic       ev;
      logic [7:0] ed;
      logic [4:0] el;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_model(input string tag);
      logic [7:0] exp_data;
      exp_data = (q.size() > 0) ? q[0] : 8'h00;
      chk({tag, ".valid"}, 32'(o_valid), 32'(q.size() > 0));
      chk({tag, ".data"},  32'(o_data),  32'(exp_data));
      chk({tag, ".level"}, 32'(o_level), 32'(q.size()));
      chk({tag, ".full"},  32'(o_full),  32'(q.size() == DEPTH));
      chk({tag, ".ovf"},   32'(o_overflow), 32'(m_ovf));
   endtask

   // One clock of traffic: drive, advance the model across the edge, compare.
   task automatic step(input logic iv, input logic [7:0] id, input logic ir, input logic ic);
      bit pop, push, full, evt;
      v = iv; d = id; r = ir; clr = ic;
      full = (q.size() == DEPTH);
      pop  = ir && (q.size() > 0);
      push = iv && (!full || pop);
      evt  = iv && full && !pop;
      @(posedge clk);
      #1;
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(id);
      if (evt)      m_ovf = 1'b1;
      else if (ic)  m_ovf = 1'b0;
      $display("t=%0t v=%0b d=%02h r=%0b clr=%0b -> valid=%0b data=%02h level=%0d full=%0b ovf=%0b",
               $time, iv, id, ir, ic, o_valid, o_data, o_level, o_full, o_overflow);
      chk_model("step");
   endtask

   task automatic do_reset();
      v = 1'b0; r = 1'b0; clr = 1'b0; d = 8'h00;
      rst = 1'b1;
      #2;
      q.delete();
      m_ovf = 1'b0;
      chk_model("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk_model("post_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //          v  d      r  c  ev ed     el
      tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1};
      tbl[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd2};
      tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h3C, 5'd1};
      tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0};
      tbl[5] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 5'd1};
      tbl[6] = '{1'b1, 8'hC3, 1'b1, 1'b0, 1'b1, 8'hC3, 5'd1};
      tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hC3, 5'd1};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0};

      #2;
      do_reset();
      chk("reset.valid", 32'(o_valid), 32'd0);
      chk("reset.level", 32'(o_level), 32'd0);

      // Basic ordering and simultaneous push/pop vectors.
      for (int i = 0; i < 9; i++) begin
         step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].c);
         chk($sformatf("tbl%0d.valid", i), 32'(o_valid), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d.data", i),  32'(o_data),  32'(tbl[i].ed));
         chk($sformatf("tbl%0d.level", i), 32'(o_level), 32'(tbl[i].el));
      end

      // Fill, overflow drop, then drain.
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      step(1'b1, 8'hFF, 1'b0, 1'b0);
      chk("fill.full",  32'(o_full), 32'd1);
      chk("fill.level", 32'(o_level), 32'd16);
      chk("fill.ovf",   32'(o_overflow), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         chk($sformatf("drain%0d.data", i), 32'(o_data), 32'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("drain.valid", 32'(o_valid), 32'd0);
      chk("drain.data",  32'(o_data),  32'd0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr.ovf", 32'(o_overflow), 32'd0);

      // Push into a full FIFO with a concurrent pop.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b1, 1'b0);
      chk("fullpop.level", 32'(o_level), 32'd16);
      chk("fullpop.ovf",   32'(o_overflow), 32'd0);
      for (int i = 1; i <= DEPTH; i++) begin
         chk($sformatf("fullpop_drain%0d", i), 32'(o_data),
             (i == DEPTH) ? 32'h77 : 32'(8'h10 + i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end

      // Clear colliding with an overflow, then a lone clear.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      step(1'b1, 8'hEE, 1'b0, 1'b1);
      chk("clrcoll.ovf", 32'(o_overflow), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clrlone.ovf", 32'(o_overflow), 32'd0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Continuous streaming across the pointer wrap.
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 8'(8'h80 + i), 1'b1, 1'b0);
         chk($sformatf("stream%0d.data", i), 32'(o_data), 32'(8'h80 + i));
         chk($sformatf("stream%0d.level", i), 32'(o_level), 32'd1);
      end
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset while bytes are queued.
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hD0 + i), 1'b0, 1'b0);
      v = 1'b0; r = 1'b0; clr = 1'b0;
      rst = 1'b1;
      #2;
      chk("midrst.valid", 32'(o_valid), 32'd0);
      chk("midrst.level", 32'(o_level), 32'd0);
      q.delete();
      m_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         chk($sformatf("postrst%0d.valid", i), 32'(o_valid), 32'd0);
      end
      step(1'b1, 8'h99, 1'b0, 1'b0);
      chk("postrst.push", 32'(o_data), 32'h99);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 15) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/x_uart_rx_fifo.md
X_UART_RX_FIFO -- requirements
Module: x_uart_rx_fifo

Interface
REQ-001 Parameter: p_depth, default 16, number of byte entries; power of two, >= 2.
REQ-002 Port: i_clk  input  1  rising-edge clock, shared with the UART receiver.
REQ-003 Port: i_rst  input  1  asynchronous, active-high reset.
REQ-004 Port: i_valid  input  1  single-cycle strobe from the receiver: byte available.
REQ-005 Port: i_data  input  8  received byte; qualified by i_valid.
REQ-006 Port: o_valid  output  1  head byte available (FIFO not empty).
REQ-007 Port: o_data  output  8  head byte; first-word-fall-through.
REQ-008 Port: i_ready  input  1  consumer accepts the head byte this cycle.
REQ-009 Port: o_level  output  $clog2(p_depth)+1  current occupancy, 0..p_depth.
REQ-010 Port: o_full  output  1  o_level == p_depth.
REQ-011 Port: o_overflow  output  1  sticky flag: a byte was dropped.
REQ-012 Port: i_clr_overflow  input  1  synchronous clear of o_overflow.

Function
REQ-013 Push condition: i_valid & (~o_full | pop), where pop = o_valid & i_ready.
- A full FIFO SHALL accept a push when a pop occurs in the same cycle.
REQ-014 Push behaviour:
- Writes i_data at the write pointer.
- Advances the write pointer by 1 on the next rising edge.
REQ-015 Pop behaviour: pop SHALL advance the read pointer by 1; i_ready while o_valid=0 SHALL have no effect.
REQ-016 Pointer format: read and write pointers are $clog2(p_depth)+1 bits.
- Wrap naturally modulo 2*p_depth.
- Full: MSBs differ, remaining bits equal.
- Empty: pointers equal.
REQ-017 o_level SHALL equal write pointer minus read pointer (modulo arithmetic, width per REQ-009).
- Push only: +1. Pop only: -1. Push and pop together: unchanged.
REQ-018 Output timing: o_valid, o_data, o_full and o_level SHALL be combinational from registered pointers and storage.
- No combinational path from i_valid, i_data or i_ready to any output.
REQ-019 Latency: a byte pushed into an empty FIFO at edge N SHALL appear with o_valid=1 in the cycle after edge N.
REQ-020 Ordering: bytes SHALL be delivered in arrival order, with no duplication or loss except per REQ-021.
REQ-021 Overflow drop: i_valid while o_full with no concurrent pop SHALL:
- drop the byte;
- leave pointers and storage unchanged;
- set o_overflow on the next edge.
REQ-022 Overflow clear: i_clr_overflow SHALL clear o_overflow on the next edge; a simultaneous overflow event SHALL take priority (flag set).
REQ-023 Empty output: o_data SHALL be 8'h00 whenever o_valid=0.

Reset
REQ-024 On i_rst, asynchronously:
- pointers = 0, o_overflow = 0;
- hence o_valid = 0, o_data = 8'h00, o_level = 0, o_full = 0.
REQ-025 Storage array contents SHALL NOT be reset.
REQ-026 Reset asserted mid-operation SHALL discard all queued bytes; no byte SHALL be presented after reset release until a new push.

Structure
REQ-027 Shared package x_uart_pkg SHALL hold the byte-width constant (8), used by this block and the UART TX/RX blocks.
REQ-028 Storage SHALL be a sub-module x_uart_fifo_mem:
- parameterised by depth;
- one synchronous write port;
- one asynchronous read port;
- no reset.
REQ-029 Pointer, level and overflow logic SHALL reside in x_uart_rx_fifo.

Verification
REQ-030 Basic order: reset, push 8'hA5 then 8'h3C with i_ready=0 -> o_level=2, o_data=8'hA5; assert i_ready 2 cycles -> 8'hA5 then 8'h3C delivered, o_valid=0, o_data=8'h00.
REQ-031 Fill and overflow (p_depth=16): push 16 bytes 0x00..0x0F, then push 0xFF -> o_full=1, o_level=16, o_overflow=1; drain yields 0x00..0x0F only.
REQ-032 Push at full with pop: full FIFO, i_valid with 0x77 and i_ready in the same cycle -> o_level stays 16, o_overflow stays 0, 0x77 is delivered last.
REQ-033 Wrap-around: 40 bytes streamed with i_ready=1 continuously -> every byte delivered one cycle after push, in order, o_level <= 1 throughout.
REQ-034 Overflow clear: i_clr_overflow and an overflowing push in the same cycle -> o_overflow=1; a later lone i_clr_overflow -> o_overflow=0.
REQ-035 Mid-operation reset: assert i_rst with 5 bytes queued -> o_valid=0, o_level=0 immediately; after release, no output until a new push.
